// File: rtl/itoh_tsujii_sequencer.sv
// Itoh-Tsujii field-inversion sequencer: walks an addition-chain ROM, issuing squaring runs and multiplies.
// Optional busy-cycle counter on cycle_count is built when INV_CYCLE_COUNT_EN is defined.
module itoh_tsujii_sequencer #(
    parameter int          CHAIN_LEN = 11,
    parameter int          ADDR_W    = 4,
    parameter int          CNT_W     = 8,
    parameter logic [3:0]  SEL_IN    = 4'd6,
    parameter logic [3:0]  SEL_ACC   = 4'd7,
    parameter logic [3:0]  SEL_SQ    = 4'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done_primitive,
    input  logic [CNT_W:0]    rom_dout,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [8:0]        control_group3,
    output logic              busy,
    output logic              done_inversion,
    output logic [15:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SQ, S_SQ_NEXT, S_LOAD2, S_MUL, S_FSQ, S_DONE
    } state_t;

    // One extra address bit lets CHAIN_LEN == 2**ADDR_W be detected after the visible address wraps.
    localparam logic [ADDR_W:0] END_ADDR = (ADDR_W + 1)'(CHAIN_LEN);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_addr, w_addr_nxt;
    logic              r_first, w_first_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic              w_accept;
    logic [3:0]        w_base_sel;
    logic [1:0]        w_base_en;
    logic [1:0]        w_mode;
    logic              w_en_prim;
    logic              w_msel;
    logic [CNT_W-1:0]  w_rom_cnt;

    assign w_msel    = rom_dout[CNT_W];
    assign w_rom_cnt = rom_dout[CNT_W-1:0];
    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_first <= 1'b1;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_first <= w_first_nxt;
            r_count <= w_count_nxt;
        end
    end

    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_first_nxt = r_first;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                    w_addr_nxt  = '0;
                    w_first_nxt = 1'b1;
                end
            end
            S_LOAD: begin
                w_count_nxt = w_rom_cnt;
                w_state_nxt = (w_rom_cnt == '0) ? S_LOAD2 : S_SQ;
            end
            S_SQ: begin
                if (done_primitive) w_state_nxt = S_SQ_NEXT;
            end
            S_SQ_NEXT: begin
                w_count_nxt = r_count - CNT_W'(1);
                w_state_nxt = (r_count == CNT_W'(1)) ? S_LOAD2 : S_SQ;
            end
            S_LOAD2: begin
                w_addr_nxt  = r_addr + (ADDR_W + 1)'(1);
                w_state_nxt = S_MUL;
            end
            S_MUL: begin
                w_first_nxt = 1'b0;
                if (done_primitive) w_state_nxt = (r_addr == END_ADDR) ? S_FSQ : S_LOAD;
            end
            S_FSQ: begin
                if (done_primitive) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath control decode; mode 0 = multiply, 1 = square.
    always_comb begin
        w_base_sel = 4'd0;
        w_base_en  = 2'd0;
        w_mode     = 2'd0;
        w_en_prim  = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_base_sel = r_first ? SEL_IN : SEL_ACC;
                w_base_en  = 2'd1;
            end
            S_SQ: begin
                w_base_sel = SEL_SQ;
                w_mode     = 2'd1;
                w_en_prim  = 1'b1;
            end
            S_SQ_NEXT: begin
                w_base_sel = SEL_SQ;
                w_base_en  = 2'd1;
                w_mode     = 2'd1;
            end
            S_LOAD2: begin
                w_base_sel = w_msel ? SEL_IN : SEL_ACC;
                w_base_en  = 2'd2;
            end
            S_MUL: begin
                w_base_sel = SEL_ACC;
                w_en_prim  = 1'b1;
            end
            S_FSQ: begin
                w_base_sel = SEL_ACC;
                w_mode     = 2'd1;
                w_en_prim  = 1'b1;
            end
            S_DONE: w_base_sel = SEL_SQ;
            default: ;
        endcase
    end

    assign control_group3 = {w_base_sel, w_base_en, w_mode, w_en_prim};
    assign rom_addr       = r_addr[ADDR_W-1:0];
    assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done_inversion = (r_state == S_DONE);

`ifdef INV_CYCLE_COUNT_EN
    logic [15:0] r_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= '0;
        end else if (w_accept) begin
            r_cycles <= '0;
        end else if (busy && (r_cycles != 16'hFFFF)) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign cycle_count = r_cycles;
`else
    assign cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_itoh_tsujii_sequencer.sv
// Self-checking bench for itoh_tsujii_sequencer: a trace model built from the chain ROM and primitive latencies
// predicts every output on every cycle; a responder models the multiplier/squarer handshake.
module tb_itoh_tsujii_sequencer;

    localparam int L = 11;
`ifdef INV_CYCLE_COUNT_EN
    localparam bit CYC_ON = 1'b1;
`else
    localparam bit CYC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done_primitive = 1'b0;
    logic [8:0]  rom_dout;
    logic [3:0]  rom_addr;
    logic [8:0]  control_group3;
    logic        busy;
    logic        done_inversion;
    logic [15:0] cycle_count;

    logic [8:0]  rom_mem [16];
    assign rom_dout = rom_mem[rom_addr];

    always #5 clk = ~clk;

    itoh_tsujii_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .done_primitive (done_primitive),
        .rom_dout       (rom_dout),
        .rom_addr       (rom_addr),
        .control_group3 (control_group3),
        .busy           (busy),
        .done_inversion (done_inversion),
        .cycle_count    (cycle_count)
    );

    typedef struct {
        logic [8:0]  cg;
        logic        busy;
        logic        dinv;
        logic [3:0]  addr;
        logic [15:0] cyc;
        bit          acc;   // start is pulsed during this (IDLE/DONE) cycle
    } exp_t;

    exp_t exp_q[$];
    exp_t trace[$];
    exp_t ce;
    int   total = 0;
    int   bad = 0;
    int   lat [64];
    int   opcnt = 0;
    int   model_n;
    logic [15:0] held_cyc = 16'd0;
    bit   was_done = 1'b0;
    int   pin_cg [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] cgw(input logic [3:0] sel, input logic [1:0] en,
                                       input logic [1:0] mode, input logic prim);
        return {sel, en, mode, prim};
    endfunction

    function exp_t idle_or_done(input bit acc);
        exp_t e;
        e.acc  = acc;
        e.busy = 1'b0;
        e.cyc  = held_cyc;
        if (was_done) begin
            e.cg   = cgw(4'd1, 2'd0, 2'd0, 1'b0);
            e.dinv = 1'b1;
            e.addr = 4'(L);
        end else begin
            e.cg   = 9'd0;
            e.dinv = 1'b0;
            e.addr = 4'd0;
        end
        return e;
    endfunction

    task automatic add_busy(input logic [8:0] cg, input int addr);
        exp_t e;
        e.cg   = cg;
        e.busy = 1'b1;
        e.dinv = 1'b0;
        e.addr = addr[3:0];
        e.cyc  = CYC_ON ? model_n[15:0] : 16'd0;
        e.acc  = 1'b0;
        trace.push_back(e);
        model_n++;
    endtask

    // Expected per-cycle outputs of one inversion: start cycle, the chain walk, final squaring, DONE hold.
    task automatic build();
        int   op;
        int   cnt;
        logic msel;
        trace.delete();
        model_n = 0;
        op = 0;
        trace.push_back(idle_or_done(1'b1));
        for (int i = 0; i < L; i++) begin
            cnt  = int'(rom_mem[i][7:0]);
            msel = rom_mem[i][8];
            add_busy(cgw((i == 0) ? 4'd6 : 4'd7, 2'd1, 2'd0, 1'b0), i);
            for (int s = 0; s < cnt; s++) begin
                for (int d = 0; d <= lat[op]; d++) add_busy(cgw(4'd1, 2'd0, 2'd1, 1'b1), i);
                op++;
                add_busy(cgw(4'd1, 2'd1, 2'd1, 1'b0), i);
            end
            add_busy(cgw(msel ? 4'd6 : 4'd7, 2'd2, 2'd0, 1'b0), i);
            for (int d = 0; d <= lat[op]; d++) add_busy(cgw(4'd7, 2'd0, 2'd0, 1'b1), i + 1);
            op++;
        end
        for (int d = 0; d <= lat[op]; d++) add_busy(cgw(4'd7, 2'd0, 2'd1, 1'b1), L);
        was_done = 1'b1;
        held_cyc = CYC_ON ? model_n[15:0] : 16'd0;
        repeat (3) trace.push_back(idle_or_done(1'b0));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending entries want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_run();
        @(posedge clk);
        #2;
        foreach (trace[k]) exp_q.push_back(trace[k]);
        drain();
    endtask

    task automatic randomize_rom();
        for (int i = 0; i < 16; i++)
            rom_mem[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 3))};
        for (int j = 0; j < 64; j++) lat[j] = $urandom_range(0, 3);
    endtask

    // Multiplier/squarer model: done rises lat[op] cycles into each operation; random noise when idle.
    logic       prev_en = 1'b0;
    logic [8:0] prev_cg = 9'd0;
    int         wcnt = 0;
    int         cur_w = 0;
    always @(negedge clk) begin
        if (control_group3 == cgw(4'd6, 2'd1, 2'd0, 1'b0)) opcnt = 0;
        if (control_group3[0]) begin
            if (!prev_en || control_group3 != prev_cg) begin
                wcnt  = 0;
                cur_w = (opcnt < 64) ? lat[opcnt] : 0;
                opcnt++;
            end else begin
                wcnt++;
            end
            done_primitive = (wcnt >= cur_w);
        end else begin
            done_primitive = 1'($urandom_range(0, 1));
        end
        prev_en = control_group3[0];
        prev_cg = control_group3;
    end

    // Compare process; also drives start (pulse on accept cycles, noise while busy).
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            check("control_group3", 32'(control_group3), 32'(ce.cg));
            check("busy", 32'(busy), 32'(ce.busy));
            check("done_inversion", 32'(done_inversion), 32'(ce.dinv));
            check("rom_addr", 32'(rom_addr), 32'(ce.addr));
            check("cycle_count", 32'(cycle_count), 32'(ce.cyc));
            if (ce.acc) start = 1'b1;
            else if (ce.busy) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = 9'd0;
        for (int j = 0; j < 64; j++) lat[j] = 0;
        pin_cg = '{200, 35, 35, 42, 208, 225, 225, 232, 35, 35, 42, 35, 35, 42, 240, 225, 225, 232, 240};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) exp_q.push_back(idle_or_done(1'b0));
        drain();

        // Directed chain: {1,1},{0,2},{0,0}, then random entries; every primitive answers after one wait.
        randomize_rom();
        rom_mem[0] = {1'b1, 8'd1};
        rom_mem[1] = {1'b0, 8'd2};
        rom_mem[2] = {1'b0, 8'd0};
        for (int j = 0; j < 64; j++) lat[j] = 1;
        build();
        for (int k = 0; k < 19; k++) check("pin_trace", 32'(trace[k + 1].cg), 32'(pin_cg[k]));
        check("pin_done_word", 32'(trace[trace.size() - 1].cg), 32'h020);
        start_run();

        // Random chains and latencies; restarts from DONE with start noise while busy.
        for (int r = 0; r < 6; r++) begin
            randomize_rom();
            build();
            start_run();
        end

        // Reset during a squaring whose done is already high.
        randomize_rom();
        rom_mem[0] = {1'b1, 8'd2};
        lat[0] = 0;
        build();
        while (trace.size() > 3) void'(trace.pop_back());
        @(posedge clk);
        #2;
        foreach (trace[k]) exp_q.push_back(trace[k]);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        was_done = 1'b0;
        held_cyc = 16'd0;
        exp_q.push_back(idle_or_done(1'b0));
        @(posedge clk);
        #2 rst = 1'b0;
        drain();

        randomize_rom();
        build();
        start_run();

        // Fixed chain, every primitive takes three cycles.
        for (int i = 0; i < 16; i++) rom_mem[i] = {1'(i % 2), 8'(i % 4)};
        for (int j = 0; j < 64; j++) lat[j] = 2;
        build();
        check("pin_busy_total", 32'(model_n), 32'd118);
        start_run();
        check("cycle_count_final", 32'(cycle_count), CYC_ON ? 32'd118 : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
